// File: rtl/result_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_serializer_if : vector-in / element-out stream bundle          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface result_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_ELEM     = 4
);
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  logic                         in_vld;
  logic                         in_rdy;
  logic [N_ELEM*DATA_WIDTH-1:0] in_data;
  logic                         result_vld;
  logic                         result_rdy;
  logic [DATA_WIDTH-1:0]        result_data;
  logic [IDX_W-1:0]             result_idx;
  logic                         result_last;

  // Upstream producer / downstream consumer side
  modport master (
    output in_vld, in_data, result_rdy,
    input  in_rdy, result_vld, result_data, result_idx, result_last
  );

  // Serializer side
  modport slave (
    input  in_vld, in_data, result_rdy,
    output in_rdy, result_vld, result_data, result_idx, result_last
  );
endinterface
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_serializer : accepts a result vector, emits one element/beat   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module result_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_ELEM     = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  result_serializer_if.slave   bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] vec_cnt
);
  localparam int                IDX_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int                BUF_W    = N_ELEM * DATA_WIDTH;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last;
  logic                  in_rdy;

  assign last   = (state_q == EMIT) && (idx_q == LAST_IDX);
  // Ready passes straight through from result_rdy on the final beat so a
  // new vector can replace the drained one without a bubble.
  assign in_rdy = (state_q == IDLE) || (last && bus.result_rdy);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (state_q == EMIT && bus.result_rdy) begin
      if (last) begin
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        data_d = buf_q[DATA_WIDTH-1:0];
        buf_d  = buf_q >> DATA_WIDTH;
      end
    end

    // The buffer holds only the not-yet-presented elements, element 0 goes
    // straight into the output register.
    if (bus.in_vld && in_rdy) begin
      data_d  = bus.in_data[DATA_WIDTH-1:0];
      buf_d   = bus.in_data >> DATA_WIDTH;
      idx_d   = '0;
      state_d = EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
    buf_q <= buf_d;
  end

  assign bus.in_rdy      = in_rdy;
  assign bus.result_vld  = (state_q == EMIT);
  assign bus.result_data = data_q;
  assign bus.result_idx  = idx_q;
  assign bus.result_last = last;
  assign busy            = (state_q == EMIT);
  assign vec_cnt         = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_result_serializer : directed bench for result_serializer           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_result_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: 4 x 16-bit elements, 16-bit counter
  result_serializer_if #(.DATA_WIDTH(16), .N_ELEM(4)) m_if ();
  logic        m_busy;
  logic [15:0] m_cnt;
  result_serializer #(.DATA_WIDTH(16), .N_ELEM(4), .CNT_WIDTH(16)) u_main (
    .clk(clk), .rst(rst), .bus(m_if.slave), .busy(m_busy), .vec_cnt(m_cnt)
  );

  // Counter-wrap instance: 2-bit counter
  result_serializer_if #(.DATA_WIDTH(16), .N_ELEM(4)) w_if ();
  logic        w_busy;
  logic [1:0]  w_cnt;
  result_serializer #(.DATA_WIDTH(16), .N_ELEM(4), .CNT_WIDTH(2)) u_wrap (
    .clk(clk), .rst(rst), .bus(w_if.slave), .busy(w_busy), .vec_cnt(w_cnt)
  );

  // Single-element instance
  result_serializer_if #(.DATA_WIDTH(16), .N_ELEM(1)) s_if ();
  logic        s_busy;
  logic [15:0] s_cnt;
  result_serializer #(.DATA_WIDTH(16), .N_ELEM(1), .CNT_WIDTH(16)) u_single (
    .clk(clk), .rst(rst), .bus(s_if.slave), .busy(s_busy), .vec_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_if.in_vld = 0; m_if.in_data = '0; m_if.result_rdy = 0;
    w_if.in_vld = 0; w_if.in_data = '0; w_if.result_rdy = 0;
    s_if.in_vld = 0; s_if.in_data = '0; s_if.result_rdy = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if (m_if.result_vld !== 1'b0 || m_if.result_data !== 16'd0 || m_if.result_idx !== 2'd0 ||
        m_if.result_last !== 1'b0 || m_busy !== 1'b0 || m_cnt !== 16'd0 || m_if.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset: vld=%0d data=%0d idx=%0d last=%0d busy=%0d cnt=%0d rdy=%0d, required 0 0 0 0 0 0 1",
               m_if.result_vld, m_if.result_data, m_if.result_idx, m_if.result_last, m_busy, m_cnt, m_if.in_rdy);
    end
  endtask

  task automatic test_single_vector();
    m_if.in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    m_if.in_vld = 1; m_if.result_rdy = 1;
    checks++;
    if (m_if.in_rdy !== 1'b1) begin
      errors++; $display("FAIL single_idle_rdy: got %0d, required 1", m_if.in_rdy);
    end
    tick();
    m_if.in_vld = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_if.result_vld !== 1'b1 || m_if.result_data !== 16'(k + 1) || m_if.result_idx !== 2'(k) ||
          m_if.result_last !== (k == 3) || m_busy !== 1'b1 || m_if.in_rdy !== (k == 3)) begin
        errors++;
        $display("FAIL single_beat%0d: vld=%0d data=%0d idx=%0d last=%0d busy=%0d rdy=%0d, required 1 %0d %0d %0d 1 %0d",
                 k, m_if.result_vld, m_if.result_data, m_if.result_idx, m_if.result_last, m_busy, m_if.in_rdy,
                 k + 1, k, (k == 3), (k == 3));
      end
      tick();
    end
    checks++;
    if (m_if.result_vld !== 1'b0 || m_busy !== 1'b0 || m_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_done: vld=%0d busy=%0d cnt=%0d, required 0 0 1", m_if.result_vld, m_busy, m_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int exp_data;
    m_if.in_data = {16'd13, 16'd12, 16'd11, 16'd10};
    m_if.in_vld = 1; m_if.result_rdy = 1;
    tick();
    m_if.in_data = {16'd23, 16'd22, 16'd21, 16'd20};
    for (int b = 0; b < 8; b++) begin
      if (b == 4) m_if.in_vld = 0;
      exp_data = (b < 4) ? 10 + b : 20 + b - 4;
      checks++;
      if (m_if.result_vld !== 1'b1 || m_if.result_data !== 16'(exp_data) || m_if.result_idx !== 2'(b % 4) ||
          m_if.in_rdy !== ((b % 4) == 3)) begin
        errors++;
        $display("FAIL b2b_beat%0d: vld=%0d data=%0d idx=%0d rdy=%0d, required 1 %0d %0d %0d",
                 b, m_if.result_vld, m_if.result_data, m_if.result_idx, m_if.in_rdy, exp_data, b % 4, ((b % 4) == 3));
      end
      tick();
    end
    checks++;
    if (m_if.result_vld !== 1'b0 || m_cnt !== 16'd3) begin
      errors++;
      $display("FAIL b2b_done: vld=%0d cnt=%0d, required 0 3", m_if.result_vld, m_cnt);
    end
  endtask

  task automatic test_backpressure();
    int e = 0;
    int cyc = 0;
    m_if.in_data = {16'h34, 16'h33, 16'h32, 16'h31};
    m_if.in_vld = 1; m_if.result_rdy = 1;
    tick();
    m_if.in_vld = 0;
    m_if.in_data = {16'hEE, 16'hEE, 16'hEE, 16'hEE};
    while (e < 4 && cyc < 20) begin
      m_if.result_rdy = ((cyc % 3) == 0);
      #0;
      checks++;
      if (m_if.result_vld !== 1'b1 || m_if.result_data !== 16'(16'h31 + e) || m_if.result_idx !== 2'(e) ||
          m_if.in_rdy !== (e == 3 && m_if.result_rdy)) begin
        errors++;
        $display("FAIL bp_cyc%0d: vld=%0d data=%h idx=%0d rdy=%0d, required 1 %h %0d %0d",
                 cyc, m_if.result_vld, m_if.result_data, m_if.result_idx, m_if.in_rdy,
                 16'(16'h31 + e), e, (e == 3 && m_if.result_rdy));
      end
      if (m_if.result_rdy) e++;
      tick();
      cyc++;
    end
    checks++;
    if (e != 4) begin
      errors++; $display("FAIL bp_timeout: transferred %0d elements, required 4", e);
    end
    checks++;
    if (m_if.result_vld !== 1'b0 || m_cnt !== 16'd4) begin
      errors++;
      $display("FAIL bp_done: vld=%0d cnt=%0d, required 0 4", m_if.result_vld, m_cnt);
    end
    m_if.result_rdy = 1;
  endtask

  task automatic test_mid_reset();
    m_if.in_data = {16'h44, 16'h43, 16'h42, 16'h41};
    m_if.in_vld = 1; m_if.result_rdy = 1;
    tick();
    m_if.in_vld = 0;
    tick(); tick();
    checks++;
    if (m_if.result_data !== 16'h43 || m_if.result_idx !== 2'd2) begin
      errors++;
      $display("FAIL mid_pre: data=%h idx=%0d, required 43 2", m_if.result_data, m_if.result_idx);
    end
    m_if.result_rdy = 0;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (m_if.result_vld !== 1'b0 || m_busy !== 1'b0 || m_cnt !== 16'd0 || m_if.in_rdy !== 1'b1 ||
        m_if.result_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: vld=%0d busy=%0d cnt=%0d rdy=%0d idx=%0d, required 0 0 0 1 0",
               m_if.result_vld, m_busy, m_cnt, m_if.in_rdy, m_if.result_idx);
    end
    m_if.result_rdy = 1;
    tick();
    checks++;
    if (m_if.result_vld !== 1'b0) begin
      errors++; $display("FAIL mid_no_beat: vld=%0d, required 0", m_if.result_vld);
    end
    m_if.in_data = {16'h54, 16'h53, 16'h52, 16'h51};
    m_if.in_vld = 1;
    tick();
    m_if.in_vld = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_if.result_vld !== 1'b1 || m_if.result_data !== 16'(16'h51 + k) || m_if.result_idx !== 2'(k)) begin
        errors++;
        $display("FAIL mid_fresh%0d: vld=%0d data=%h idx=%0d, required 1 %h %0d",
                 k, m_if.result_vld, m_if.result_data, m_if.result_idx, 16'(16'h51 + k), k);
      end
      tick();
    end
    checks++;
    if (m_cnt !== 16'd1) begin
      errors++; $display("FAIL mid_cnt: cnt=%0d, required 1", m_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    w_if.result_rdy = 1;
    for (int v = 0; v < 5; v++) begin
      w_if.in_data = {16'(v * 4 + 3), 16'(v * 4 + 2), 16'(v * 4 + 1), 16'(v * 4)};
      w_if.in_vld = 1;
      tick();
      w_if.in_vld = 0;
      checks++;
      if (w_if.result_data !== 16'(v * 4)) begin
        errors++; $display("FAIL wrap_first%0d: data=%0d, required %0d", v, w_if.result_data, v * 4);
      end
      tick(); tick(); tick(); tick();
      checks++;
      if (w_cnt !== 2'((v + 1) % 4) || w_busy !== 1'b0) begin
        errors++;
        $display("FAIL wrap_cnt%0d: cnt=%0d busy=%0d, required %0d 0", v, w_cnt, w_busy, (v + 1) % 4);
      end
    end
  endtask

  task automatic test_single_elem();
    s_if.result_rdy = 1;
    s_if.in_data = 16'd7;
    s_if.in_vld = 1;
    checks++;
    if (s_if.in_rdy !== 1'b1) begin
      errors++; $display("FAIL n1_idle_rdy: got %0d, required 1", s_if.in_rdy);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) s_if.in_data = 16'(8 + k);
      else s_if.in_vld = 0;
      #0;
      checks++;
      if (s_if.result_vld !== 1'b1 || s_if.result_data !== 16'(7 + k) || s_if.result_last !== 1'b1 ||
          s_if.result_idx !== 1'b0 || s_if.in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL n1_beat%0d: vld=%0d data=%0d last=%0d idx=%0d rdy=%0d, required 1 %0d 1 0 1",
                 k, s_if.result_vld, s_if.result_data, s_if.result_last, s_if.result_idx, s_if.in_rdy, 7 + k);
      end
      tick();
    end
    checks++;
    if (s_if.result_vld !== 1'b0 || s_cnt !== 16'd3) begin
      errors++;
      $display("FAIL n1_done: vld=%0d cnt=%0d, required 0 3", s_if.result_vld, s_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_cnt_wrap();
    test_single_elem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
